// File: rtl/trng_vn_packer.sv
// Von Neumann debiaser and LSB-first word packer for the PDL entropy source; z reaches the pair FSM after SYNC_STAGES edges.
// A word is valid from the edge that samples its final pair; a full, unaccepted output register drops new words and sets sticky overflow.
module trng_vn_packer #(
    parameter int OUT_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic                   en,
    input  logic                   z,
    output logic [OUT_W-1:0]       dout,
    output logic                   dout_valid,
    input  logic                   dout_ready,
    output logic                   overflow,
    output logic [$clog2(OUT_W):0] bit_cnt
);

    localparam int CNT_W = $clog2(OUT_W) + 1;

    typedef enum logic {
        WAIT_A = 1'b0,
        WAIT_B = 1'b1
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   zs;

    state_e                 state_q, state_d;
    logic                   a_q;
    logic                   a_ld;
    logic                   emit;
    logic                   emit_bit;

    logic [OUT_W-1:0]       sr_q, sr_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [OUT_W-1:0]       word_new;
    logic                   last_bit;
    logic                   word_done;

    logic [OUT_W-1:0]       dout_q, dout_d;
    logic                   dout_valid_q, dout_valid_d;
    logic                   overflow_q, overflow_d;
    logic                   accept;

    // Synchroniser runs independently of en so zs is always settled.
    always_ff @(posedge clk) begin
        if (clr) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], z};
        end
    end

    assign zs = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= WAIT_A;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = WAIT_A;
        end else begin
            case (state_q)
                WAIT_A:  state_d = WAIT_B;
                WAIT_B:  state_d = WAIT_A;
                default: state_d = WAIT_A;
            endcase
        end
    end

    always_comb begin
        a_ld     = 1'b0;
        emit     = 1'b0;
        emit_bit = a_q;
        if (en) begin
            case (state_q)
                WAIT_A:  a_ld = 1'b1;
                WAIT_B:  emit = (a_q != zs);
                default: a_ld = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            a_q <= 1'b0;
        end else if (a_ld) begin
            a_q <= zs;
        end
    end

    // Word including the bit being emitted this cycle, used both for packing and for the output load.
    always_comb begin
        word_new = sr_q;
        for (int i = 0; i < OUT_W; i++) begin
            if (bit_cnt_q == CNT_W'(i)) begin
                word_new[i] = emit_bit;
            end
        end
    end

    assign last_bit  = (bit_cnt_q == CNT_W'(OUT_W - 1));
    assign word_done = emit && last_bit;

    always_comb begin
        sr_d      = sr_q;
        bit_cnt_d = bit_cnt_q;
        if (emit) begin
            if (last_bit) begin
                sr_d      = '0;
                bit_cnt_d = '0;
            end else begin
                sr_d      = word_new;
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            sr_q      <= '0;
            bit_cnt_q <= '0;
        end else begin
            sr_q      <= sr_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    assign accept = dout_valid_q && dout_ready;

    // A word completing in the same cycle as an accept replaces the departing one.
    always_comb begin
        dout_d       = dout_q;
        dout_valid_d = dout_valid_q;
        overflow_d   = overflow_q;
        if (word_done) begin
            if (!dout_valid_q || accept) begin
                dout_d       = word_new;
                dout_valid_d = 1'b1;
            end else begin
                overflow_d   = 1'b1;
            end
        end else if (accept) begin
            dout_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            overflow_q   <= overflow_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign overflow   = overflow_q;
    assign bit_cnt    = bit_cnt_q;

    a_hold_stable: assert property (@(posedge clk) disable iff (clr)
        (dout_valid_q && !dout_ready) |=> (dout_valid_q && $stable(dout_q)));

endmodule

// File: tb/tb_trng_vn_packer.sv
// Directed bench for trng_vn_packer (OUT_W=8, SYNC_STAGES=2): table of packed words plus corner-case sequences.
// z and controls change on negedge; outputs are compared at negedge.
module tb_trng_vn_packer;

    localparam int OUT_W = 8;

    logic       clk = 1'b0;
    logic       clr;
    logic       en;
    logic       z;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_ready;
    logic       overflow;
    logic [3:0] bit_cnt;

    int tests = 0;
    int fails = 0;

    logic zq[$];
    logic saw_valid;
    int   max_cnt;

    typedef struct {
        logic [31:0] seq;
        int          n;
        logic [7:0]  exp_dout;
    } vec_t;

    vec_t vt[5];

    always #5 clk = ~clk;

    trng_vn_packer #(.OUT_W(OUT_W), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .clr        (clr),
        .en         (en),
        .z          (z),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .overflow   (overflow),
        .bit_cnt    (bit_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Called at a negedge; drives inputs, lets one posedge pass, returns at the next negedge.
    task automatic tick(input logic e, input logic r, input logic zv);
        en         = e;
        dout_ready = r;
        z          = zv;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push_pairs(input logic a, input logic b, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            zq.push_back(a);
            zq.push_back(b);
        end
    endtask

    // Two disabled priming cycles fill the synchroniser, so enabled edge k consumes zq[k].
    task automatic feed(input logic r, input logic r_last);
        int n;
        n         = zq.size();
        saw_valid = 1'b0;
        max_cnt   = 0;
        for (int i = 0; i < n + 2; i++) begin
            if (dout_valid) saw_valid = 1'b1;
            if (int'(bit_cnt) > max_cnt) max_cnt = int'(bit_cnt);
            tick(i >= 2, (i == n + 1) ? r_last : r, (i < n) ? zq[i] : 1'b0);
        end
        zq.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000 ns, limit 200000 ns");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vt[0] = '{32'h0000_5555, 16, 8'hFF};
        vt[1] = '{32'h0000_6666, 16, 8'hAA};
        vt[2] = '{32'h0000_AAAA, 16, 8'h00};
        vt[3] = '{32'h00AA_1D1D, 24, 8'h0F};
        vt[4] = '{32'h0000_9969, 16, 8'h59};

        clr        = 1'b1;
        en         = 1'b1;
        z          = 1'b0;
        dout_ready = 1'b1;
        @(negedge clk);

        // Reset with z toggling and en high, then idle with en low.
        tick(1'b1, 1'b1, 1'b1);
        tick(1'b1, 1'b1, 1'b0);
        chk("rst_dout", 32'(dout), 32'h0);
        chk("rst_valid", 32'(dout_valid), 32'h0);
        chk("rst_overflow", 32'(overflow), 32'h0);
        chk("rst_bit_cnt", 32'(bit_cnt), 32'h0);
        clr = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 1'b0, (i % 2) == 1);
            chk($sformatf("idle_%0d", i), {19'h0, dout, dout_valid, overflow, bit_cnt}, 32'h0);
        end

        // Constant z yields only equal pairs.
        for (int i = 0; i < 100; i++) zq.push_back(1'b1);
        for (int i = 0; i < 100; i++) zq.push_back(1'b0);
        feed(1'b1, 1'b1);
        chk("bias_saw_valid", 32'(saw_valid), 32'h0);
        chk("bias_max_bit_cnt", 32'(max_cnt), 32'h0);
        chk("bias_end_valid", 32'(dout_valid), 32'h0);
        chk("bias_end_bit_cnt", 32'(bit_cnt), 32'h0);

        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < vt[v].n; i++) zq.push_back(vt[v].seq[i]);
            feed(1'b1, 1'b1);
            chk($sformatf("vec%0d_early_valid", v), 32'(saw_valid), 32'h0);
            chk($sformatf("vec%0d_valid", v), 32'(dout_valid), 32'h1);
            chk($sformatf("vec%0d_dout", v), 32'(dout), 32'(vt[v].exp_dout));
            chk($sformatf("vec%0d_bit_cnt", v), 32'(bit_cnt), 32'h0);
            chk($sformatf("vec%0d_overflow", v), 32'(overflow), 32'h0);
            tick(1'b0, 1'b1, 1'b0);
            chk($sformatf("vec%0d_valid_after_accept", v), 32'(dout_valid), 32'h0);
            chk($sformatf("vec%0d_dout_kept", v), 32'(dout), 32'(vt[v].exp_dout));
        end

        // Half pair (zs=1) abandoned by en=0, then pair 01 emits a 0.
        zq.push_back(1'b1);
        feed(1'b1, 1'b1);
        chk("abort_half_bit_cnt", 32'(bit_cnt), 32'h0);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b1);
        push_pairs(1'b0, 1'b1, 1);
        feed(1'b1, 1'b1);
        chk("abort_bit_cnt", 32'(bit_cnt), 32'h1);
        push_pairs(1'b1, 1'b0, 7);
        feed(1'b1, 1'b1);
        chk("abort_valid", 32'(dout_valid), 32'h1);
        chk("abort_dout", 32'(dout), 32'hFE);
        tick(1'b0, 1'b1, 1'b0);

        // Word completes on the same edge the held word is accepted.
        push_pairs(1'b1, 1'b0, 8);
        feed(1'b0, 1'b0);
        chk("swap_first_dout", 32'(dout), 32'hFF);
        push_pairs(1'b0, 1'b1, 8);
        feed(1'b0, 1'b1);
        chk("swap_valid", 32'(dout_valid), 32'h1);
        chk("swap_dout", 32'(dout), 32'h00);
        chk("swap_overflow", 32'(overflow), 32'h0);
        tick(1'b0, 1'b1, 1'b0);
        chk("swap_drained", 32'(dout_valid), 32'h0);

        // Backpressure: FF held, later words dropped.
        push_pairs(1'b1, 1'b0, 16);
        feed(1'b0, 1'b0);
        chk("bp_dout", 32'(dout), 32'hFF);
        chk("bp_valid", 32'(dout_valid), 32'h1);
        chk("bp_overflow", 32'(overflow), 32'h1);
        push_pairs(1'b0, 1'b1, 16);
        feed(1'b0, 1'b0);
        chk("bp_dout_held", 32'(dout), 32'hFF);
        chk("bp_bit_cnt", 32'(bit_cnt), 32'h0);
        tick(1'b0, 1'b1, 1'b0);
        chk("bp_valid_after_accept", 32'(dout_valid), 32'h0);
        chk("bp_overflow_sticky", 32'(overflow), 32'h1);
        tick(1'b0, 1'b0, 1'b0);
        chk("bp_overflow_sticky2", 32'(overflow), 32'h1);

        // Mid-word reset leaves no residue.
        push_pairs(1'b1, 1'b0, 5);
        feed(1'b1, 1'b1);
        chk("mid_bit_cnt", 32'(bit_cnt), 32'h5);
        clr = 1'b1;
        tick(1'b1, 1'b1, 1'b1);
        clr = 1'b0;
        chk("mid_clr_bit_cnt", 32'(bit_cnt), 32'h0);
        chk("mid_clr_overflow", 32'(overflow), 32'h0);
        chk("mid_clr_dout", 32'(dout), 32'h0);
        push_pairs(1'b1, 1'b0, 8);
        feed(1'b1, 1'b1);
        chk("mid_valid", 32'(dout_valid), 32'h1);
        chk("mid_dout", 32'(dout), 32'hFF);
        tick(1'b0, 1'b1, 1'b0);
        push_pairs(1'b1, 1'b0, 5);
        feed(1'b1, 1'b1);
        clr = 1'b1;
        tick(1'b0, 1'b1, 1'b0);
        clr = 1'b0;
        push_pairs(1'b0, 1'b1, 8);
        feed(1'b1, 1'b1);
        chk("mid2_dout", 32'(dout), 32'h00);
        chk("mid2_valid", 32'(dout_valid), 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/trng_vn_packer.md
Name: trng_vn_packer

Overview:
Downstream stage of the PDL entropy source. Samples the PDL output `z` each clock and removes bias with a von Neumann corrector. Packs the corrected bits into OUT_W-bit words and presents them on a valid/ready interface to the TRNG output logic or FIFO. Reports lost words through a sticky overflow flag.

Parameters:
OUT_W, 8, width of the packed output word (2..32)
SYNC_STAGES, 2, number of flops in the synchroniser on `z` (>=2)

Ports:
clk  input  1  system clock
clr  input  1  reset, synchronous, active-high
en  input  1  sampling enable; same enable that gates the PDL
z  input  1  raw PDL output; asynchronous to clk
dout  output  OUT_W  packed random word
dout_valid  output  1  dout holds an unconsumed word
dout_ready  input  1  consumer accepts dout when high together with dout_valid
overflow  output  1  sticky; a completed word was dropped
bit_cnt  output  $clog2(OUT_W)+1  corrected bits in the current partial word (debug)

Behaviour:
- Clocking and reset: one clock `clk`. Reset `clr` is synchronous and active-high.
- While `clr`=1 at a clk edge, all state clears:
  - sync chain 0, pair FSM = WAIT_A, shift reg 0, bit_cnt 0
  - dout 0, dout_valid 0, overflow 0
  - `clr` overrides all other inputs, including mid-word and mid-handshake.
- Synchroniser: `z` passes through SYNC_STAGES flops and runs regardless of `en`. The last stage, zs, is the sampled bit.
- Pair FSM, advancing once per cycle with `en`=1:
  - WAIT_A: latch a = zs, go to WAIT_B.
  - WAIT_B: b = zs, go to WAIT_A.
    - a != b: emit corrected bit = a (10 -> 1, 01 -> 0).
    - a == b: discard both, emit nothing.
- `en`=0: FSM forced to WAIT_A, so a half pair is discarded. Shift reg, bit_cnt and output register hold.
- Packing:
  - Emitted bits fill LSB-first: the first corrected bit lands in bit 0. bit_cnt increments per emitted bit.
  - When the OUT_W-th bit is emitted, the completed word goes to the output stage. In the same cycle bit_cnt returns to 0 and the shift reg clears.
- Output stage, evaluated at the edge where a word completes:
  - Register empty, or being accepted that cycle (dout_valid & dout_ready): load dout with the new word; dout_valid=1 on the next cycle.
  - Register full and not accepted: drop the new word, set overflow=1, keep dout/dout_valid unchanged. Packing continues.
- Handshake:
  - Accept with no new word that cycle: dout_valid -> 0 next cycle; dout keeps its last value.
  - dout must stay stable while dout_valid=1 and dout_ready=0.
- Latency: a transition on `z` reaches zs after SYNC_STAGES edges. The word completes on the WAIT_B sample of its final pair, and dout_valid rises at that same edge.
- overflow clears only on `clr`.
- Throughput bound: at most 1 word per 2*OUT_W enabled cycles.

Test Plan:
OUT_W=8, SYNC_STAGES=2 for all scenarios; `z` driven on negedge.

1. Reset: clr=1 for 2 cycles with z toggling -> dout=0, dout_valid=0, overflow=0, bit_cnt=0. Release clr with en=0 for 10 cycles -> outputs unchanged.
2. Bias rejection: en=1, z held 1 for 100 cycles, then held 0 for 100 cycles -> dout_valid never asserts, bit_cnt stays 0.
3. Pattern packing: en=1, ready=1, zs pairs 10,10,... (16 samples) -> dout=8'hFF, dout_valid=1 for one cycle. Then pairs alternating 01,10 -> dout=8'hAA.
4. Backpressure: ready=0, feed 16 pairs "10" then 16 pairs "01":
   - first word 8'hFF held
   - second word dropped, overflow=1
   - raise ready for 1 cycle -> dout_valid=0 next cycle, overflow stays 1
5. Enable abort: en=1 for one WAIT_A sample (zs=1), en=0 for 3 cycles, then en=1 with pair 01 -> emitted bit 0 (stale half pair discarded); bit_cnt=1.
6. Mid-word reset: feed 5 corrected bits, assert clr one cycle -> bit_cnt=0. The next 8 pairs "10" produce exactly 8'hFF, with no residue from the earlier bits.
